// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: cause codes, status bit index, vectors, FSM states and EPC helper for exc_ctrl
package exc_ctrl_pkg;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;
  localparam int STATUS_BEV = 22;
  localparam logic [31:0] DEF_VEC_BEV1 = 32'hBFC0_0380;
  localparam logic [31:0] DEF_VEC_BEV0 = 32'h8000_0180;
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, REDIR = 2'd2} state_t;
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? pc - 32'd4 : pc;
  endfunction
endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: commit-stage faults, cp0 exception port, bus-drain and fetch-redirect signals
//   master: commit/cp0/bus/fetch environment (drives cm_*, int_resp, cp0_*, bus_idle, redirect_ready)
//   slave : exc_ctrl (drives cm_kill, exc_*, flush, redirect_*)
interface exc_ctrl_if;
  logic        cm_valid;
  logic [31:0] cm_pc;
  logic        cm_bd;
  logic        cm_adel_if;
  logic        cm_ri;
  logic        cm_ov;
  logic        cm_sys;
  logic        cm_bp;
  logic        cm_trap;
  logic        cm_adel_ld;
  logic        cm_ades_st;
  logic [31:0] cm_addr;
  logic        cm_eret;
  logic        int_resp;
  logic [31:0] cp0_status;
  logic [31:0] cp0_epc;
  logic        bus_idle;
  logic        redirect_ready;
  logic        cm_kill;
  logic        exc_valid;
  logic [4:0]  exc_excode;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic [31:0] exc_badvaddr;
  logic        exc_eret;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  modport master(
    output cm_valid, cm_pc, cm_bd, cm_adel_if, cm_ri, cm_ov, cm_sys, cm_bp, cm_trap,
           cm_adel_ld, cm_ades_st, cm_addr, cm_eret, int_resp, cp0_status, cp0_epc,
           bus_idle, redirect_ready,
    input  cm_kill, exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr, exc_eret,
           flush, redirect_valid, redirect_pc
  );
  modport slave(
    input  cm_valid, cm_pc, cm_bd, cm_adel_if, cm_ri, cm_ov, cm_sys, cm_bp, cm_trap,
           cm_adel_ld, cm_ades_st, cm_addr, cm_eret, int_resp, cp0_status, cp0_epc,
           bus_idle, redirect_ready,
    output cm_kill, exc_valid, exc_excode, exc_bd, exc_epc, exc_badvaddr, exc_eret,
           flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: priority encoder from commit fault flags to {hit, eret, badvaddr_sel, code}
//   inputs : int_i, adel_if_i, ri_i, ov_i, trap_i, sys_i, bp_i, adel_ld_i, ades_i, eret_i
//   outputs: hit_o (any event), eret_o (eret wins), badvaddr_sel_o (1=pc, 0=data addr), code_o
//   EXC_TRAP_EN: when defined trap_i raises Tr; otherwise trap_i is ignored
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic       int_i,
  input  logic       adel_if_i,
  input  logic       ri_i,
  input  logic       ov_i,
  input  logic       trap_i,
  input  logic       sys_i,
  input  logic       bp_i,
  input  logic       adel_ld_i,
  input  logic       ades_i,
  input  logic       eret_i,
  output logic       hit_o,
  output logic       eret_o,
  output logic       badvaddr_sel_o,
  output logic [4:0] code_o
);
  logic tr;
  logic fault;
`ifdef EXC_TRAP_EN
  assign tr = trap_i;
`else
  logic unused_trap;
  assign unused_trap = trap_i;
  assign tr = 1'b0;
`endif
  always_comb begin
    fault = int_i | adel_if_i | ri_i | ov_i | tr | sys_i | bp_i | adel_ld_i | ades_i;
    hit_o = fault | eret_i;
    eret_o = !fault & eret_i;
    badvaddr_sel_o = adel_if_i;
    code_o = int_i     ? EXC_INT  :
             adel_if_i ? EXC_ADEL :
             ri_i      ? EXC_RI   :
             ov_i      ? EXC_OV   :
             tr        ? EXC_TR   :
             sys_i     ? EXC_SYS  :
             bp_i      ? EXC_BP   :
             adel_ld_i ? EXC_ADEL :
             ades_i    ? EXC_ADES : 5'd0;
  end
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: commit-boundary exception/ERET sequencer (prioritise, pulse cp0, flush, drain bus, redirect fetch)
//   clk, resetn (async active-low)
//   bus (exc_ctrl_if.slave): commit flags/pc/addr, int_resp, cp0_status/epc, bus_idle, redirect_ready in;
//                            cm_kill, exc_* pulse, flush, redirect_valid/pc out
//   EXC_TRAP_EN: enables cm_trap as cause 13
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] VEC_BEV1 = DEF_VEC_BEV1,
  parameter logic [31:0] VEC_BEV0 = DEF_VEC_BEV0
) (
  input logic        clk,
  input logic        resetn,
  exc_ctrl_if.slave  bus
);
  state_t      state_q, state_d;
  logic        hit, eret_hit, bsel, ev;
  logic [4:0]  code;
  logic        valid_q, bd_q, eret_q;
  logic [4:0]  code_q;
  logic [31:0] epc_q, badv_q, target_q;
  exc_prio_enc u_prio (
    .int_i         (bus.int_resp),
    .adel_if_i     (bus.cm_adel_if),
    .ri_i          (bus.cm_ri),
    .ov_i          (bus.cm_ov),
    .trap_i        (bus.cm_trap),
    .sys_i         (bus.cm_sys),
    .bp_i          (bus.cm_bp),
    .adel_ld_i     (bus.cm_adel_ld),
    .ades_i        (bus.cm_ades_st),
    .eret_i        (bus.cm_eret),
    .hit_o         (hit),
    .eret_o        (eret_hit),
    .badvaddr_sel_o(bsel),
    .code_o        (code)
  );
  // resetn gates the kill so every output reads 0 while reset is held
  assign ev = resetn && state_q == IDLE && bus.cm_valid && hit;
  always_comb begin
    state_d = state_q == IDLE  ? (ev ? DRAIN : IDLE) :
              state_q == DRAIN ? (bus.bus_idle ? REDIR : DRAIN) :
              state_q == REDIR ? (bus.redirect_ready ? IDLE : REDIR) : IDLE;
  end
  assign bus.cm_kill        = ev;
  assign bus.exc_valid      = valid_q;
  assign bus.exc_excode     = valid_q ? code_q : 5'd0;
  assign bus.exc_bd         = valid_q & bd_q;
  assign bus.exc_epc        = valid_q ? epc_q : 32'd0;
  assign bus.exc_badvaddr   = valid_q ? badv_q : 32'd0;
  assign bus.exc_eret       = valid_q & eret_q;
  assign bus.flush          = state_q != IDLE;
  assign bus.redirect_valid = state_q == REDIR;
  assign bus.redirect_pc    = state_q == REDIR ? target_q : 32'd0;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      code_q   <= 5'd0;
      bd_q     <= 1'b0;
      eret_q   <= 1'b0;
      epc_q    <= 32'd0;
      badv_q   <= 32'd0;
      target_q <= 32'd0;
    end else begin
      state_q <= state_d;
      valid_q <= ev;
      if (ev) begin
        code_q   <= code;
        bd_q     <= bus.cm_bd;
        eret_q   <= eret_hit;
        epc_q    <= epc_of(bus.cm_pc, bus.cm_bd);
        badv_q   <= bsel ? bus.cm_pc : bus.cm_addr;
        target_q <= eret_hit ? bus.cp0_epc : bus.cp0_status[STATUS_BEV] ? VEC_BEV1 : VEC_BEV0;
      end
    end
  end
endmodule
